mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multi-cycle control sequencer for the single-cycle execute datapath (decoder, register file, ALU, data memory). It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It gates the datapath write strobes (IR, PC, register file, data memory) so that exactly one architectural update happens per state. It handles variable-latency instruction and data memories with ready handshakes, a timeout fault, an external stall, and a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, default 15: cycles waited in FETCH/MEM without ready before FAULT.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `CLK`  in  1: single clock, rising-edge.
- `RST_N`  in  1: reset, asynchronous, active-low.
- `start`  in  1: leave IDLE and begin fetching; in FAULT, return to IDLE.
- `stall`  in  1: freeze the sequencer in its current state.
- `imem_ready`  in  1: instruction word valid this cycle.
- `dmem_ready`  in  1: data memory accepted the write or returned read data this cycle.
- `dec_reg_write`, `dec_mem_read`, `dec_mem_write`, `dec_jump`, `dec_branch`, `dec_halt`  in  1 each: decoder flags for the current IR.
- `alu_zero`  in  1: ALU zero flag.
- `ir_load`  out  1: IR write enable.
- `pc_load`  out  1: PC write enable.
- `pc_sel`  out  2: next-PC source; 00 = PC+4, 01 = branch target, 10 = jump target.
- `reg_we`  out  1: register-file write enable.
- `dmem_re`, `dmem_we`  out  1 each: data-memory read and write requests.
- `running`  out  1: high when the state is not IDLE and not FAULT.
- `fault`  out  1: high in FAULT.
- `state`  out  3: current state encoding.
- `retired`  out  CNT_W: count of completed instructions.

## Operation
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, FAULT = 6.
- IDLE: `start` moves to FETCH.
- FETCH: `imem_ready` pulses `ir_load` and moves to DECODE.
- DECODE: `dec_halt` moves to IDLE and increments `retired`, with no `pc_load`. If `dec_mem_read` and `dec_mem_write` are both high, move to FAULT. Otherwise move to EXEC.
- EXEC, first match wins:
  - `dec_jump`: `pc_load`, `pc_sel` = 10, move to FETCH.
  - `dec_branch`: `pc_load`, `pc_sel` = (`alu_zero` ? 01 : 00), move to FETCH.
  - `dec_mem_read` or `dec_mem_write`: move to MEM.
  - Otherwise: move to WB.
  - Jump and branch increment `retired`.
- MEM: `dmem_re`/`dmem_we` follow the decoder flags and are held until `dmem_ready`.
  - Read + ready: move to WB.
  - Write + ready: `pc_load`, `pc_sel` = 00, increment `retired`, move to FETCH.
- WB: `reg_we` = `dec_reg_write`, `pc_load`, `pc_sel` = 00, increment `retired`, move to FETCH.
- FAULT: sticky. `start` returns to IDLE and clears `fault`.
- `stall` high in FETCH through WB:
  - State and the wait counter hold.
  - `ir_load`, `pc_load`, `reg_we`, `dmem_re` and `dmem_we` are forced to 0.
  - A ready arriving in the same cycle is ignored, so the memory must hold ready.
- Wait counter:
  - Clears on every state change.
  - Increments each unstalled cycle spent in FETCH or MEM without ready.
  - Reaching `MEM_TIMEOUT` moves to FAULT.
  - If ready arrives in the same cycle, ready wins.
- `retired` wraps modulo 2^CNT_W.
- `pc_sel` is 00 in every cycle without `pc_load`.

## Timing
- Registered: state, wait counter, `retired`.
- Strobes are combinational from state, decoder flags, readies and `stall`. They are valid in the cycle before the edge that performs the update.
- Reset (`RST_N` low, asynchronous): state = IDLE, wait counter = 0, `retired` = 0, all strobes 0, `running` = 0, `fault` = 0.
- Reset asserted mid-instruction aborts it with no further strobes.
- Minimum cycles per instruction with zero wait states:
  - ALU: 4.
  - Load: 5.
  - Store: 4.
  - Branch or jump: 3.
  - Halt: 2.
- Each memory wait cycle adds 1. The first FETCH follows one cycle after `start`.

## Structure
- Shared package/include holds:
  - State encodings.
  - `pc_sel` constants.
  - The default value of `MEM_TIMEOUT`.
- Sub-module `wait_timer`:
  - Clear, enable and hit inputs; terminal-count output at `MEM_TIMEOUT`.
  - Instantiated once and shared by FETCH and MEM.

## Test plan
- ALU instruction: `start`, `imem_ready` = 1, `dec_reg_write` = 1 -> states 1, 2, 3, 5, 1. `ir_load` fires in FETCH. `reg_we` and `pc_load` fire in WB with `pc_sel` = 00. `retired` = 1.
- Load with 3 wait cycles on `dmem_ready` -> `dmem_re` is held for 4 cycles, then WB asserts `reg_we`; instruction takes 8 cycles.
- Branch with `alu_zero` = 1, then with `alu_zero` = 0 -> `pc_sel` = 01, then 00; each takes 3 cycles with no `reg_we`.
- `imem_ready` held low for 15 cycles -> FAULT, `fault` = 1, `running` = 0. `start` -> IDLE.
- `stall` high for 5 cycles in MEM while `dmem_ready` = 1 -> no strobes and state held; completion follows in the first cycle after `stall` drops.
- `dec_halt` -> IDLE after 2 cycles, `retired` +1. `RST_N` low mid-WB -> IDLE and `retired` = 0 immediately.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// mc_sequencer_pkg
// Shared definitions for the multi-cycle control sequencer:
//   - state_t   : FSM state encodings (also driven out on the `state` port)
//   - PC_SEL_*  : next-PC source select values
//   - DEF_MEM_TIMEOUT : default memory wait budget in cycles
package mc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;  // branch target
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;  // jump target

    localparam int DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/mc_sequencer_wait_timer.sv
// mc_sequencer_wait_timer
// Counts unanswered memory wait cycles. One instance is shared by the FETCH
// and MEM states of the sequencer.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : zero the count (the sequencer changes state)
//   en_i          : a waiting cycle is in progress (FETCH/MEM, not stalled)
//   hit_i         : the awaited ready arrived this cycle
//   tc_o          : this waiting cycle is the MEM_TIMEOUT-th without ready
module mc_sequencer_wait_timer
    import mc_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    input  logic hit_i,
    output logic tc_o
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready in the same cycle wins over the timeout.
    assign tc_o = en_i && !hit_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer
// Multi-cycle control sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and gates the datapath write
// strobes so exactly one architectural update happens per state.
// Ports:
//   CLK, RST_N            : clock, asynchronous active-low reset
//   start                 : leave IDLE / clear FAULT
//   stall                 : freeze state, wait counter and all strobes
//   imem_ready/dmem_ready : memory handshakes (must be held across a stall)
//   dec_*                 : decoder flags for the current IR
//   alu_zero              : ALU zero flag for branch resolution
//   ir_load, pc_load, pc_sel, reg_we, dmem_re, dmem_we : datapath strobes,
//                           combinational, valid in the cycle before the edge
//   running, fault, state : status / debug view of the FSM
//   retired               : completed-instruction counter (wraps)
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             dec_reg_write,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_jump,
    input  logic             dec_branch,
    input  logic             dec_halt,
    input  logic             alu_zero,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             running,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             wait_en, wait_hit, wait_tc, wait_clr;

    // Timer inputs depend only on registered state and primary inputs.
    assign wait_en  = !stall && (state_q == ST_FETCH || state_q == ST_MEM);
    assign wait_hit = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
    assign wait_clr = (state_d != state_q);

    mc_sequencer_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .clear_i (wait_clr),
        .en_i    (wait_en),
        .hit_i   (wait_hit),
        .tc_o    (wait_tc)
    );

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        pc_load = 1'b0;
        pc_sel  = PC_SEL_SEQ;
        reg_we  = 1'b0;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!stall) begin
                    if (imem_ready) begin
                        ir_load = 1'b1;
                        state_d = ST_DECODE;
                    end else if (wait_tc) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    if (dec_halt) begin
                        retire  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (dec_mem_read && dec_mem_write) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (dec_jump) begin
                        pc_load = 1'b1;
                        pc_sel  = PC_SEL_JUMP;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (dec_branch) begin
                        pc_load = 1'b1;
                        pc_sel  = alu_zero ? PC_SEL_BRANCH : PC_SEL_SEQ;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (dec_mem_read || dec_mem_write) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_MEM: begin
                if (!stall) begin
                    dmem_re = dec_mem_read;
                    dmem_we = dec_mem_write;
                    if (dmem_ready && dec_mem_read) begin
                        state_d = ST_WB;
                    end else if (dmem_ready && dec_mem_write) begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (wait_tc) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_WB: begin
                if (!stall) begin
                    reg_we  = dec_reg_write;
                    pc_load = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    assign running = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign fault   = (state_q == ST_FAULT);
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        start, stall, imem_ready, dmem_ready;
  logic        dec_reg_write, dec_mem_read, dec_mem_write;
  logic        dec_jump, dec_branch, dec_halt, alu_zero;
  logic        ir_load, pc_load, reg_we, dmem_re, dmem_we, running, fault;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] retired;

  // Observed snapshot: {state, ir_load, pc_load, pc_sel, reg_we, dmem_re, dmem_we}
  logic [9:0]  snap;
  assign snap = {state, ir_load, pc_load, pc_sel, reg_we, dmem_re, dmem_we};

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_cnt = 0;

  mc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stall(stall),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .dec_mem_write(dec_mem_write), .dec_jump(dec_jump),
    .dec_branch(dec_branch), .dec_halt(dec_halt), .alu_zero(alu_zero),
    .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .reg_we(reg_we),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .running(running), .fault(fault),
    .state(state), .retired(retired)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled at +2, well away from both edges.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
    cyc_cnt++;
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; imem_ready = 0; dmem_ready = 0;
    dec_reg_write = 0; dec_mem_read = 0; dec_mem_write = 0;
    dec_jump = 0; dec_branch = 0; dec_halt = 0; alu_zero = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 0;
    next_cycle();
    RST_N = 1;
  endtask

  // Issue start from IDLE; the following cycle is the first FETCH.
  task automatic issue_start();
    next_cycle(); start = 1; #1;
    next_cycle(); start = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    #2 RST_N = 0;
    next_cycle(); #1;
    tests_run++; if (snap !== 10'd0) begin tests_failed++; $display("FAIL reset_strobes: got %b want %b", snap, 10'd0); end
    tests_run++; if ({running, fault} !== 2'b00) begin tests_failed++; $display("FAIL reset_status: got %b want 00", {running, fault}); end
    tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL reset_retired: got %0d want 0", retired); end
    RST_N = 1;
  endtask

  task automatic test_alu();
    logic [9:0] exp_v;
    int f0;
    do_reset();
    next_cycle(); start = 1; #1;
    exp_v = {3'd0, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL alu_idle: got %b want %b", snap, exp_v); end
    next_cycle(); start = 0; imem_ready = 1; dec_reg_write = 1; #1; f0 = cyc_cnt;
    exp_v = {3'd1, 7'b1000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL alu_fetch: got %b want %b", snap, exp_v); end
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL alu_running: got %b want 1", running); end
    next_cycle(); #1;
    exp_v = {3'd2, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL alu_decode: got %b want %b", snap, exp_v); end
    next_cycle(); #1;
    exp_v = {3'd3, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL alu_exec: got %b want %b", snap, exp_v); end
    next_cycle(); #1;
    exp_v = {3'd5, 7'b0100100}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL alu_wb: got %b want %b", snap, exp_v); end
    tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL alu_retired_pre: got %0d want 0", retired); end
    next_cycle(); imem_ready = 0; #1;
    tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL alu_next_fetch: got %0d want 1", state); end
    tests_run++; if (retired !== 32'd1) begin tests_failed++; $display("FAIL alu_retired: got %0d want 1", retired); end
    tests_run++; if (cyc_cnt - f0 !== 4) begin tests_failed++; $display("FAIL alu_cycles: got %0d want 4", cyc_cnt - f0); end
  endtask

  task automatic test_load_wait();
    logic [9:0] exp_v;
    int f0;
    do_reset();
    issue_start();
    imem_ready = 1; dec_mem_read = 1; dec_reg_write = 1; #1; f0 = cyc_cnt;
    exp_v = {3'd1, 7'b1000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL load_fetch: got %b want %b", snap, exp_v); end
    next_cycle(); imem_ready = 0; #1;
    exp_v = {3'd2, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL load_decode: got %b want %b", snap, exp_v); end
    next_cycle(); #1;
    exp_v = {3'd3, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL load_exec: got %b want %b", snap, exp_v); end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      exp_v = {3'd4, 7'b0000010}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL load_mem_wait%0d: got %b want %b", i, snap, exp_v); end
    end
    next_cycle(); dmem_ready = 1; #1;
    exp_v = {3'd4, 7'b0000010}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL load_mem_ready: got %b want %b", snap, exp_v); end
    next_cycle(); dmem_ready = 0; #1;
    exp_v = {3'd5, 7'b0100100}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL load_wb: got %b want %b", snap, exp_v); end
    next_cycle(); #1;
    tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL load_next_fetch: got %0d want 1", state); end
    tests_run++; if (retired !== 32'd1) begin tests_failed++; $display("FAIL load_retired: got %0d want 1", retired); end
    tests_run++; if (cyc_cnt - f0 !== 8) begin tests_failed++; $display("FAIL load_cycles: got %0d want 8", cyc_cnt - f0); end
  endtask

  task automatic test_branch();
    logic [9:0] exp_v;
    int f0;
    do_reset();
    issue_start();
    imem_ready = 1; dec_branch = 1; alu_zero = 1; #1; f0 = cyc_cnt;
    next_cycle(); imem_ready = 0; #1;
    exp_v = {3'd2, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL br_taken_decode: got %b want %b", snap, exp_v); end
    next_cycle(); #1;
    exp_v = {3'd3, 7'b0101000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL br_taken_exec: got %b want %b", snap, exp_v); end
    next_cycle(); alu_zero = 0; imem_ready = 1; #1;
    tests_run++; if (cyc_cnt - f0 !== 3) begin tests_failed++; $display("FAIL br_taken_cycles: got %0d want 3", cyc_cnt - f0); end
    tests_run++; if (retired !== 32'd1) begin tests_failed++; $display("FAIL br_taken_retired: got %0d want 1", retired); end
    f0 = cyc_cnt;
    next_cycle(); imem_ready = 0; #1;
    next_cycle(); #1;
    exp_v = {3'd3, 7'b0100000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL br_not_taken_exec: got %b want %b", snap, exp_v); end
    // Jump with branch also set: jump has priority.
    next_cycle(); dec_jump = 1; alu_zero = 1; imem_ready = 1; #1;
    tests_run++; if (cyc_cnt - f0 !== 3) begin tests_failed++; $display("FAIL br_not_taken_cycles: got %0d want 3", cyc_cnt - f0); end
    exp_v = {3'd1, 7'b1000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL jump_fetch: got %b want %b", snap, exp_v); end
    next_cycle(); imem_ready = 0; #1;
    next_cycle(); #1;
    exp_v = {3'd3, 7'b0110000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL jump_exec: got %b want %b", snap, exp_v); end
    next_cycle(); #1;
    tests_run++; if (retired !== 32'd3) begin tests_failed++; $display("FAIL jump_retired: got %0d want 3", retired); end
  endtask

  task automatic test_timeout();
    logic [9:0] exp_v;
    do_reset();
    issue_start();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) next_cycle();
      #1;
      exp_v = {3'd1, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL to_wait%0d: got %b want %b", i, snap, exp_v); end
    end
    next_cycle(); #1;
    exp_v = {3'd6, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL to_fault_state: got %b want %b", snap, exp_v); end
    tests_run++; if ({running, fault} !== 2'b01) begin tests_failed++; $display("FAIL to_fault_status: got %b want 01", {running, fault}); end
    next_cycle(); imem_ready = 1; #1;
    next_cycle(); imem_ready = 0; start = 1; #1;
    tests_run++; if (state !== 3'd6) begin tests_failed++; $display("FAIL to_sticky: got %0d want 6", state); end
    next_cycle(); start = 0; #1;
    tests_run++; if ({state, running, fault} !== 5'b000_00) begin tests_failed++; $display("FAIL to_clear: got %b want 00000", {state, running, fault}); end
    // Ready arriving on the 15th wait cycle wins over the timeout.
    issue_start();
    for (int i = 0; i < 13; i++) next_cycle();
    next_cycle(); imem_ready = 1; #1;
    exp_v = {3'd1, 7'b1000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL to_ready_wins: got %b want %b", snap, exp_v); end
    next_cycle(); imem_ready = 0; #1;
    tests_run++; if (state !== 3'd2) begin tests_failed++; $display("FAIL to_ready_decode: got %0d want 2", state); end
  endtask

  task automatic test_stall_fetch();
    logic [9:0] exp_v;
    do_reset();
    issue_start();
    for (int i = 0; i < 9; i++) next_cycle();
    // 10 unstalled waits done; stalled cycles must neither count nor load IR.
    for (int i = 0; i < 10; i++) begin
      next_cycle(); stall = 1; imem_ready = 1; #1;
      exp_v = {3'd1, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL stf_stall%0d: got %b want %b", i, snap, exp_v); end
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle(); stall = 0; imem_ready = 0; #1;
      tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL stf_wait%0d: got %0d want 1", i, state); end
    end
    next_cycle(); #1;
    tests_run++; if (state !== 3'd6) begin tests_failed++; $display("FAIL stf_timeout: got %0d want 6", state); end
  endtask

  task automatic test_stall_mem();
    logic [9:0] exp_v;
    do_reset();
    issue_start();
    imem_ready = 1; dec_mem_write = 1; #1;
    next_cycle(); imem_ready = 0; #1;
    next_cycle(); #1;
    exp_v = {3'd3, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL stm_exec: got %b want %b", snap, exp_v); end
    for (int i = 0; i < 5; i++) begin
      next_cycle(); stall = 1; dmem_ready = 1; #1;
      exp_v = {3'd4, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL stm_stall%0d: got %b want %b", i, snap, exp_v); end
    end
    next_cycle(); stall = 0; #1;
    exp_v = {3'd4, 7'b0100001}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL stm_release: got %b want %b", snap, exp_v); end
    next_cycle(); dmem_ready = 0; #1;
    tests_run++; if ({state, retired} !== {3'd1, 32'd1}) begin tests_failed++; $display("FAIL stm_done: got state %0d retired %0d want 1 1", state, retired); end
  endtask

  task automatic test_halt();
    logic [9:0] exp_v;
    int f0;
    do_reset();
    issue_start();
    imem_ready = 1; dec_halt = 1; #1; f0 = cyc_cnt;
    next_cycle(); imem_ready = 0; #1;
    exp_v = {3'd2, 7'b0000000}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL halt_decode: got %b want %b", snap, exp_v); end
    next_cycle(); #1;
    tests_run++; if ({state, running} !== 4'b000_0) begin tests_failed++; $display("FAIL halt_idle: got %b want 0000", {state, running}); end
    tests_run++; if (retired !== 32'd1) begin tests_failed++; $display("FAIL halt_retired: got %0d want 1", retired); end
    tests_run++; if (cyc_cnt - f0 !== 2) begin tests_failed++; $display("FAIL halt_cycles: got %0d want 2", cyc_cnt - f0); end
  endtask

  task automatic test_mem_conflict();
    do_reset();
    issue_start();
    imem_ready = 1; dec_mem_read = 1; dec_mem_write = 1; #1;
    next_cycle(); imem_ready = 0; #1;
    next_cycle(); #1;
    tests_run++; if ({state, fault, retired} !== {3'd6, 1'b1, 32'd0}) begin tests_failed++; $display("FAIL conflict_fault: got state %0d fault %b retired %0d want 6 1 0", state, fault, retired); end
  endtask

  task automatic test_reset_mid_wb();
    logic [9:0] exp_v;
    do_reset();
    issue_start();
    imem_ready = 1; dec_reg_write = 1; #1;
    for (int i = 0; i < 7; i++) next_cycle();
    #1;
    exp_v = {3'd5, 7'b0100100}; tests_run++; if (snap !== exp_v) begin tests_failed++; $display("FAIL rst_wb_pre: got %b want %b", snap, exp_v); end
    tests_run++; if (retired !== 32'd1) begin tests_failed++; $display("FAIL rst_wb_retired_pre: got %0d want 1", retired); end
    RST_N = 0; #1;
    tests_run++; if (snap !== 10'd0) begin tests_failed++; $display("FAIL rst_wb_async: got %b want %b", snap, 10'd0); end
    tests_run++; if ({retired, running, fault} !== 34'd0) begin tests_failed++; $display("FAIL rst_wb_status: got retired %0d running %b fault %b want 0 0 0", retired, running, fault); end
    next_cycle(); #1;
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL rst_wb_held: got %0d want 0", state); end
    RST_N = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_timeout();
    test_stall_fetch();
    test_stall_mem();
    test_halt();
    test_mem_conflict();
    test_reset_mid_wb();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
